decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Second pipeline stage (DE): takes instr/pc latched by fetch, decodes RV32I base
//  subset, reads 32x32 register file, builds sign-extended immediate, latches
//  operands + control for EX. Owns the register file; WB writes it back here.
//  Flush from ME (taken branch/jump) turns the latched slot into a bubble.
// PARAMETERS
//  XLEN     32  data/register width
//  PC_W     32  PC width (word-addressed, matches fetch)
//  INSTR_W  32  instruction width
// PORTS
//  clk          in   1        clock, all state on posedge
//  reset        in   1        synchronous, active-high
//  instr_i      in   INSTR_W  instruction from FE latch
//  pc_i         in   PC_W     PC of instr_i from FE latch
//  flush_i      in   1        ME redirect: squash instruction entering DE/EX latch
//  wb_we_i      in   1        WB register write enable
//  wb_rd_i      in   5        WB destination register
//  wb_data_i    in   XLEN     WB write data
//  valid_o      out  1        latched slot holds a real instruction
//  pc_o         out  PC_W     latched PC
//  rs1_data_o   out  XLEN     latched rs1 value (bypassed)
//  rs2_data_o   out  XLEN     latched rs2 value (bypassed)
//  imm_o        out  XLEN     latched sign-extended immediate
//  rs1_o/rs2_o  out  5        latched source indices (for EX forwarding)
//  rd_o         out  5        latched destination index
//  alu_op_o     out  4        0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
//  alu_src_a_o  out  2        0 rs1, 1 pc, 2 zero
//  alu_src_b_o  out  1        0 rs2, 1 imm
//  reg_we_o     out  1        writes rd (forced 0 when rd==0)
//  mem_we_o     out  1        store
//  mem_re_o     out  1        load (mem_to_reg)
//  funct3_o     out  3        latched funct3 (branch type / load-store size)
//  branch_o     out  1        conditional branch
//  jump_o       out  2        0 none, 1 JAL, 2 JALR
//  illegal_o    out  1        unsupported opcode seen (1-cycle pulse, latched)
// BEHAVIOUR
//  - Latency 1: instr_i/pc_i at edge N -> decoded outputs valid after edge N+1.
//  - Decoded opcodes: LUI(src_a=zero,PASSB style ADD imm), AUIPC(src_a=pc), JAL, JALR,
//    BRANCH, LOAD, STORE, OP-IMM, OP. Immediates I/S/B/U/J per RV32I, sign-extended
//    to XLEN; B/J immediates are byte offsets, EX converts for word-addressed PC.
//  - OP/OP-IMM: funct7[5] selects SUB (OP only) and SRA (both); SLLI/SRLI/SRAI imm=shamt.
//  - Unsupported opcode: latch as bubble (valid_o=0, all enables 0), illegal_o=1.
//  - Register file: x0 reads 0, writes to x0 ignored. Write on posedge when wb_we_i.
//  - Write-through: if wb_we_i && wb_rd_i==rsN && rsN!=0, rsN_data uses wb_data_i
//    in the same cycle (no extra stall for WB->DE hazard).
//  - flush_i at edge: latch loads bubble: valid_o, reg_we_o, mem_we_o, mem_re_o,
//    branch_o, jump_o, illegal_o all 0; data fields don't-care (drive 0).
//    Regfile write from WB in the same cycle still completes.
//  - Reset (priority over flush): all outputs 0, all 31 registers cleared to 0.
//    Reset mid-stream discards in-flight slot; WB write in reset cycle is dropped.
//  - No stall input: every cycle the latch loads a new slot.
// TESTING
//  1 addi x5,x0,-1 (0xFFF00293) -> next cycle rd_o=5 imm_o=0xFFFFFFFF alu_op_o=0 alu_src_b_o=1 reg_we_o=1
//  2 wb_we_i=1 rd=3 data=0xCAFE0001 same cycle as add x4,x3,x3 -> rs1/rs2_data_o=0xCAFE0001
//  3 WB write rd=0 data=0x1234, then add x1,x0,x0 -> rs1_data_o=rs2_data_o=0; reg_we_o for rd=0 is 0
//  4 sw x2,-4(x1) (0xFE20AE23) -> imm_o=0xFFFFFFFC mem_we_o=1 reg_we_o=0 funct3_o=2
//  5 beq with flush_i=1 -> valid_o=0 branch_o=0; next unflushed instr decodes normally
//  6 opcode 0x7F -> illegal_o=1 valid_o=0; reset mid-stream -> all outputs 0, x1..x31 read 0

Source files
------------

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Decode (DE) stage of the pipeline. It takes the instruction and PC from the
//   fetch latch and decodes the RV32I base subset. It reads operands from the
//   32x32 register file, which this stage owns and which WB writes back into.
//   It builds the sign-extended immediate and registers operands plus control
//   into the DE/EX latch. A flush from ME (taken branch/jump) loads a bubble
//   into the latch.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   instr_i, pc_i              instruction/PC from the FE latch
//   flush_i                    squash the slot entering the DE/EX latch
//   wb_we_i/wb_rd_i/wb_data_i  register file write port driven by WB
//   valid_o, pc_o              latched slot valid flag and PC
//   rs1_data_o/rs2_data_o      latched operands (WB write-through applied)
//   imm_o                      latched sign-extended immediate
//   rs1_o/rs2_o/rd_o           latched register indices
//   alu_op_o                   0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,
//                              8 OR,9 AND
//   alu_src_a_o                0 rs1, 1 pc, 2 zero
//   alu_src_b_o                0 rs2, 1 imm
//   reg_we_o, mem_we_o, mem_re_o, funct3_o, branch_o, jump_o (0/1 JAL/2 JALR)
//   illegal_o                  unsupported opcode seen in this slot
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               flush_i,
  input  logic               wb_we_i,
  input  logic [4:0]         wb_rd_i,
  input  logic [XLEN-1:0]    wb_data_i,
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [XLEN-1:0]    rs1_data_o,
  output logic [XLEN-1:0]    rs2_data_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [4:0]         rd_o,
  output logic [3:0]         alu_op_o,
  output logic [1:0]         alu_src_a_o,
  output logic               alu_src_b_o,
  output logic               reg_we_o,
  output logic               mem_we_o,
  output logic               mem_re_o,
  output logic [2:0]         funct3_o,
  output logic               branch_o,
  output logic [1:0]         jump_o,
  output logic               illegal_o
);

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  // funct3 -> ALU operation. funct7[5] picks SRA for shifts-right in both
  // forms, but SUB only for register-register ops (ADDI has no SUBI).
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                input logic       alt,
                                                input logic       reg_reg);
    logic [3:0] op;
    case (f3)
      3'd0:    op = (alt && reg_reg) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7_alt;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_idx;

  assign opcode  = instr_i[6:0];
  assign rd_idx  = instr_i[11:7];
  assign funct3  = instr_i[14:12];
  assign rs1_idx = instr_i[19:15];
  assign rs2_idx = instr_i[24:20];
  assign f7_alt  = instr_i[30];

  // Immediate formats; B/J stay byte offsets, EX rescales for word PCs.
  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;
  logic signed [31:0] imm_sh;

  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'd0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};
  assign imm_sh = {27'd0, instr_i[24:20]};

  // Decode
  logic               legal;
  logic [3:0]         alu_op_d;
  logic [1:0]         src_a_d;
  logic               src_b_d;
  logic               wr_rd_d;
  logic               mem_we_d;
  logic               mem_re_d;
  logic               branch_d;
  logic [1:0]         jump_d;
  logic signed [31:0] imm_d;

  always_comb begin
    legal    = 1'b1;
    alu_op_d = ALU_ADD;
    src_a_d  = SRC_A_RS1;
    src_b_d  = 1'b0;
    wr_rd_d  = 1'b0;
    mem_we_d = 1'b0;
    mem_re_d = 1'b0;
    branch_d = 1'b0;
    jump_d   = 2'd0;
    imm_d    = '0;
    case (opcode)
      OPC_LUI: begin
        src_a_d = SRC_A_ZERO;
        src_b_d = 1'b1;
        wr_rd_d = 1'b1;
        imm_d   = imm_u;
      end
      OPC_AUIPC: begin
        src_a_d = SRC_A_PC;
        src_b_d = 1'b1;
        wr_rd_d = 1'b1;
        imm_d   = imm_u;
      end
      OPC_JAL: begin
        jump_d  = 2'd1;
        src_a_d = SRC_A_PC;
        src_b_d = 1'b1;
        wr_rd_d = 1'b1;
        imm_d   = imm_j;
      end
      OPC_JALR: begin
        jump_d  = 2'd2;
        src_b_d = 1'b1;
        wr_rd_d = 1'b1;
        imm_d   = imm_i;
      end
      OPC_BRANCH: begin
        branch_d = 1'b1;
        alu_op_d = ALU_SUB;
        imm_d    = imm_b;
      end
      OPC_LOAD: begin
        mem_re_d = 1'b1;
        src_b_d  = 1'b1;
        wr_rd_d  = 1'b1;
        imm_d    = imm_i;
      end
      OPC_STORE: begin
        mem_we_d = 1'b1;
        src_b_d  = 1'b1;
        imm_d    = imm_s;
      end
      OPC_OPIMM: begin
        src_b_d  = 1'b1;
        wr_rd_d  = 1'b1;
        alu_op_d = alu_from_funct(funct3, f7_alt, 1'b0);
        // Shift-immediate forms carry funct7 in imm[11:5]; only shamt matters.
        imm_d    = (funct3 == 3'd1 || funct3 == 3'd5) ? imm_sh : imm_i;
      end
      OPC_OP: begin
        wr_rd_d  = 1'b1;
        alu_op_d = alu_from_funct(funct3, f7_alt, 1'b1);
      end
      default: legal = 1'b0;
    endcase
  end

  // Register file read with WB write-through
  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign rs1_val = (rs1_idx == 5'd0) ? '0 :
                   (wb_we_i && wb_rd_i == rs1_idx) ? wb_data_i : rf[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? '0 :
                   (wb_we_i && wb_rd_i == rs2_idx) ? wb_data_i : rf[rs2_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we_i && wb_rd_i != 5'd0) begin
      rf[wb_rd_i] <= wb_data_i;
    end
  end

  // ---- DE/EX latch (stage boundary p1) ----
  logic              vld_p1;
  logic [PC_W-1:0]   pc_p1;
  logic [XLEN-1:0]   rs1_data_p1;
  logic [XLEN-1:0]   rs2_data_p1;
  logic [XLEN-1:0]   imm_p1;
  logic [4:0]        rs1_p1;
  logic [4:0]        rs2_p1;
  logic [4:0]        rd_p1;
  logic [3:0]        alu_op_p1;
  logic [1:0]        src_a_p1;
  logic              src_b_p1;
  logic              reg_we_p1;
  logic              mem_we_p1;
  logic              mem_re_p1;
  logic [2:0]        funct3_p1;
  logic              branch_p1;
  logic [1:0]        jump_p1;
  logic              illegal_p1;

  always_ff @(posedge clk) begin
    if (reset || flush_i || !legal) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      alu_op_p1   <= '0;
      src_a_p1    <= '0;
      src_b_p1    <= 1'b0;
      reg_we_p1   <= 1'b0;
      mem_we_p1   <= 1'b0;
      mem_re_p1   <= 1'b0;
      funct3_p1   <= '0;
      branch_p1   <= 1'b0;
      jump_p1     <= '0;
      // An illegal opcode is only reported when the slot is not squashed.
      illegal_p1  <= !reset && !flush_i && !legal;
    end else begin
      vld_p1      <= 1'b1;
      pc_p1       <= pc_i;
      rs1_data_p1 <= rs1_val;
      rs2_data_p1 <= rs2_val;
      imm_p1      <= XLEN'(imm_d);
      rs1_p1      <= rs1_idx;
      rs2_p1      <= rs2_idx;
      rd_p1       <= rd_idx;
      alu_op_p1   <= alu_op_d;
      src_a_p1    <= src_a_d;
      src_b_p1    <= src_b_d;
      reg_we_p1   <= wr_rd_d && (rd_idx != 5'd0);
      mem_we_p1   <= mem_we_d;
      mem_re_p1   <= mem_re_d;
      funct3_p1   <= funct3;
      branch_p1   <= branch_d;
      jump_p1     <= jump_d;
      illegal_p1  <= 1'b0;
    end
  end

  assign valid_o     = vld_p1;
  assign pc_o        = pc_p1;
  assign rs1_data_o  = rs1_data_p1;
  assign rs2_data_o  = rs2_data_p1;
  assign imm_o       = imm_p1;
  assign rs1_o       = rs1_p1;
  assign rs2_o       = rs2_p1;
  assign rd_o        = rd_p1;
  assign alu_op_o    = alu_op_p1;
  assign alu_src_a_o = src_a_p1;
  assign alu_src_b_o = src_b_p1;
  assign reg_we_o    = reg_we_p1;
  assign mem_we_o    = mem_we_p1;
  assign mem_re_o    = mem_re_p1;
  assign funct3_o    = funct3_p1;
  assign branch_o    = branch_p1;
  assign jump_o      = jump_p1;
  assign illegal_o   = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [31:0] imm_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic [3:0]  alu_op_o;
  logic [1:0]  alu_src_a_o;
  logic        alu_src_b_o;
  logic        reg_we_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [2:0]  funct3_o;
  logic        branch_o;
  logic [1:0]  jump_o;
  logic        illegal_o;

  decode_stage #(.XLEN(32), .PC_W(32), .INSTR_W(32)) dut (
    .clk(clk), .reset(reset), .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .valid_o(valid_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .alu_op_o(alu_op_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .reg_we_o(reg_we_o),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .funct3_o(funct3_o), .branch_o(branch_o),
    .jump_o(jump_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Expected latched slot
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [1:0]  src_a;
    logic        src_b;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  f3;
    logic        branch;
    logic [1:0]  jump;
    logic        illegal;
  } exp_t;

  // Reference register file
  logic [31:0] rf_m [32];

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_we_i && wb_rd_i == idx) return wb_data_i;
    return rf_m[idx];
  endfunction

  // ALU code per funct3, one nibble each (funct3=0 in the low nibble)
  localparam logic [31:0] ALU_TAB = 32'h98654320;

  // Decode per the RV32I rules, computed arithmetically from the word.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1v, input logic [31:0] r2v);
    exp_t e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] sgn;
    logic [31:0] im_i, im_s, im_b, im_u, im_j;
    logic        writes;
    op  = ins[6:0];
    f3  = ins[14:12];
    sgn = ins[31] ? 32'hFFFF_FFFF : 32'd0;
    im_i = (sgn << 12) | 32'(ins[31:20]);
    im_s = (sgn << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
    im_b = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    im_u = ins & 32'hFFFF_F000;
    im_j = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    e = '0;
    e.valid = 1'b1; e.pc = pc; e.rs1d = r1v; e.rs2d = r2v;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3;
    writes = 1'b0;
    if (op == 7'h37) begin
      e.src_a = 2; e.src_b = 1; e.imm = im_u; writes = 1;
    end else if (op == 7'h17) begin
      e.src_a = 1; e.src_b = 1; e.imm = im_u; writes = 1;
    end else if (op == 7'h6F) begin
      e.jump = 1; e.src_a = 1; e.src_b = 1; e.imm = im_j; writes = 1;
    end else if (op == 7'h67) begin
      e.jump = 2; e.src_b = 1; e.imm = im_i; writes = 1;
    end else if (op == 7'h63) begin
      e.branch = 1; e.alu_op = 1; e.imm = im_b;
    end else if (op == 7'h03) begin
      e.mem_re = 1; e.src_b = 1; e.imm = im_i; writes = 1;
    end else if (op == 7'h23) begin
      e.mem_we = 1; e.src_b = 1; e.imm = im_s;
    end else if (op == 7'h13 || op == 7'h33) begin
      writes = 1;
      e.alu_op = ALU_TAB[f3*4 +: 4];
      if (f3 == 5 && ins[30]) e.alu_op = 7;
      if (op == 7'h33 && f3 == 0 && ins[30]) e.alu_op = 1;
      if (op == 7'h13) begin
        e.src_b = 1;
        e.imm = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : im_i;
      end
    end else begin
      e = '0;
      e.illegal = 1'b1;
      return e;
    end
    e.reg_we = writes && (e.rd != 0);
    return e;
  endfunction

  task automatic cmp_all(input exp_t e, input string tag);
    chk({tag, ".valid"},   valid_o,   e.valid);
    chk({tag, ".reg_we"},  reg_we_o,  e.reg_we);
    chk({tag, ".mem_we"},  mem_we_o,  e.mem_we);
    chk({tag, ".mem_re"},  mem_re_o,  e.mem_re);
    chk({tag, ".branch"},  branch_o,  e.branch);
    chk({tag, ".jump"},    jump_o,    e.jump);
    chk({tag, ".illegal"}, illegal_o, e.illegal);
    if (e.valid) begin
      chk({tag, ".pc"},     pc_o,        e.pc);
      chk({tag, ".rs1d"},   rs1_data_o,  e.rs1d);
      chk({tag, ".rs2d"},   rs2_data_o,  e.rs2d);
      chk({tag, ".imm"},    imm_o,       e.imm);
      chk({tag, ".rs1"},    rs1_o,       e.rs1);
      chk({tag, ".rs2"},    rs2_o,       e.rs2);
      chk({tag, ".rd"},     rd_o,        e.rd);
      chk({tag, ".alu_op"}, alu_op_o,    e.alu_op);
      chk({tag, ".src_a"},  alu_src_a_o, e.src_a);
      chk({tag, ".src_b"},  alu_src_b_o, e.src_b);
      chk({tag, ".f3"},     funct3_o,    e.f3);
    end
  endtask

  task automatic chk_zero(input string tag);
    exp_t z;
    z = '0;
    cmp_all(z, tag);
    chk({tag, ".pc"},     pc_o,        32'd0);
    chk({tag, ".rs1d"},   rs1_data_o,  32'd0);
    chk({tag, ".rs2d"},   rs2_data_o,  32'd0);
    chk({tag, ".imm"},    imm_o,       32'd0);
    chk({tag, ".rd"},     rd_o,        32'd0);
    chk({tag, ".alu_op"}, alu_op_o,    32'd0);
    chk({tag, ".src_a"},  alu_src_a_o, 32'd0);
    chk({tag, ".src_b"},  alu_src_b_o, 32'd0);
    chk({tag, ".f3"},     funct3_o,    32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!reset && wb_we_i && wb_rd_i != 0) rf_m[wb_rd_i] = wb_data_i;
    if (reset) for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
  endtask

  // Directed vectors: inputs, then hand-derived expectations
  typedef struct packed {
    logic [31:0] instr;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        src_b;
    logic        reg_we;
    logic        mem_we;
    logic [2:0]  f3;
    logic        branch;
    logic        illegal;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  logic [6:0] legal_ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  logic [6:0] bad_ops [3]   = '{7'h7F, 7'h0B, 7'h73};

  initial begin
    exp_t e;
    logic [31:0] r;
    string tag;

    //          instr         fl we rd  wb_data       v  rd  imm           alu sb we mw f3 br il rs1d          rs2d
    vt[0]  = '{32'hFFF00293, 0, 0, 0,  32'h0,        1, 5,  32'hFFFFFFFF, 0,  1, 1, 0, 0, 0, 0, 32'h0,        32'h0};
    vt[1]  = '{32'h00318233, 0, 1, 3,  32'hCAFE0001, 1, 4,  32'h0,        0,  0, 1, 0, 0, 0, 0, 32'hCAFE0001, 32'hCAFE0001};
    vt[2]  = '{32'h00000013, 0, 1, 0,  32'h00001234, 1, 0,  32'h0,        0,  1, 0, 0, 0, 0, 0, 32'h0,        32'h0};
    vt[3]  = '{32'h000000B3, 0, 0, 0,  32'h0,        1, 1,  32'h0,        0,  0, 1, 0, 0, 0, 0, 32'h0,        32'h0};
    vt[4]  = '{32'h00018333, 0, 0, 0,  32'h0,        1, 6,  32'h0,        0,  0, 1, 0, 0, 0, 0, 32'hCAFE0001, 32'h0};
    vt[5]  = '{32'hFE20AE23, 0, 0, 0,  32'h0,        1, 28, 32'hFFFFFFFC, 0,  1, 0, 1, 2, 0, 0, 32'h0,        32'h0};
    vt[6]  = '{32'h00000463, 1, 1, 13, 32'h13131313, 0, 0,  32'h0,        0,  0, 0, 0, 0, 0, 0, 32'h0,        32'h0};
    vt[7]  = '{32'h00000463, 0, 0, 0,  32'h0,        1, 8,  32'h8,        1,  0, 0, 0, 0, 1, 0, 32'h0,        32'h0};
    vt[8]  = '{32'h0000007F, 0, 0, 0,  32'h0,        0, 0,  32'h0,        0,  0, 0, 0, 0, 0, 1, 32'h0,        32'h0};
    vt[9]  = '{32'h123453B7, 0, 1, 9,  32'hA5A5A5A5, 1, 7,  32'h12345000, 0,  1, 1, 0, 5, 0, 0, 32'h0,        32'hCAFE0001};
    vt[10] = '{32'h00348533, 0, 0, 0,  32'h0,        1, 10, 32'h0,        0,  0, 1, 0, 0, 0, 0, 32'hA5A5A5A5, 32'hCAFE0001};
    vt[11] = '{32'h409505B3, 0, 0, 0,  32'h0,        1, 11, 32'h0,        1,  0, 1, 0, 0, 0, 0, 32'h0,        32'hA5A5A5A5};
    vt[12] = '{32'h4044D613, 0, 0, 0,  32'h0,        1, 12, 32'h4,        7,  1, 1, 0, 5, 0, 0, 32'hA5A5A5A5, 32'h0};
    vt[13] = '{32'h00068733, 0, 0, 0,  32'h0,        1, 14, 32'h0,        0,  0, 1, 0, 0, 0, 0, 32'h13131313, 32'h0};

    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    reset = 1'b1; instr_i = 32'h0000007F; pc_i = 32'h44; flush_i = 1'b0;
    wb_we_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'd0;
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      instr_i = vt[i].instr; pc_i = 32'h100 + i; flush_i = vt[i].flush;
      wb_we_i = vt[i].wb_we; wb_rd_i = vt[i].wb_rd; wb_data_i = vt[i].wb_data;
      tick();
      tag = $sformatf("vec%0d", i);
      chk({tag, ".valid"},   valid_o,   vt[i].valid);
      chk({tag, ".reg_we"},  reg_we_o,  vt[i].reg_we);
      chk({tag, ".mem_we"},  mem_we_o,  vt[i].mem_we);
      chk({tag, ".branch"},  branch_o,  vt[i].branch);
      chk({tag, ".illegal"}, illegal_o, vt[i].illegal);
      if (vt[i].valid) begin
        chk({tag, ".pc"},     pc_o,        32'h100 + i);
        chk({tag, ".rd"},     rd_o,        vt[i].rd);
        chk({tag, ".imm"},    imm_o,       vt[i].imm);
        chk({tag, ".alu_op"}, alu_op_o,    vt[i].alu_op);
        chk({tag, ".src_b"},  alu_src_b_o, vt[i].src_b);
        chk({tag, ".f3"},     funct3_o,    vt[i].f3);
        chk({tag, ".rs1d"},   rs1_data_o,  vt[i].rs1d);
        chk({tag, ".rs2d"},   rs2_data_o,  vt[i].rs2d);
      end
    end

    // Reset mid-stream: valid slot in flight plus a WB write in the reset cycle
    instr_i = 32'hFFF00293; pc_i = 32'h200; flush_i = 1'b0;
    wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h0000DEAD;
    reset = 1'b1;
    tick();
    chk_zero("midreset");
    reset = 1'b0; wb_we_i = 1'b0;
    for (int k = 1; k < 32; k++) begin
      instr_i = (32'(k) << 20) | (32'(k) << 15) | 32'h33;
      tick();
      tag = $sformatf("clr_x%0d", k);
      chk({tag, ".rs1d"}, rs1_data_o, 32'd0);
      chk({tag, ".rs2d"}, rs2_data_o, 32'd0);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      if ($urandom_range(0, 9) == 9)
        instr_i = {r[31:7], bad_ops[$urandom_range(0, 2)]};
      else
        instr_i = {r[31:7], legal_ops[$urandom_range(0, 8)]};
      pc_i      = $urandom;
      flush_i   = ($urandom_range(0, 7) == 0);
      wb_we_i   = $urandom_range(0, 1);
      wb_data_i = $urandom;
      case ($urandom_range(0, 3))
        0:       wb_rd_i = instr_i[19:15];
        1:       wb_rd_i = instr_i[24:20];
        default: wb_rd_i = 5'($urandom);
      endcase
      if (flush_i) e = '0;
      else e = ref_decode(instr_i, pc_i, mread(instr_i[19:15]), mread(instr_i[24:20]));
      tick();
      cmp_all(e, $sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
